echo_indication_serializer: RTL and testbench



---
 rtl/echo_indication_pkg.sv | 28 ++
 rtl/echo_indication_serializer_if.sv | 36 +++
 rtl/echo_indication_serializer.sv | 108 ++++++++++
 tb/tb_echo_indication_serializer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/echo_indication_pkg.sv
// Shared types and constants for the EchoIndication serializer:
// method ids, message lengths, the header word layout and the FSM states.
package echo_indication_pkg;

    localparam logic [15:0] HEARD_ID   = 16'd0;
    localparam logic [15:0] HEARDS_ID  = 16'd1;
    localparam logic [15:0] HEARD_LEN  = 16'd2;
    localparam logic [15:0] HEARDS_LEN = 16'd4;

    // Header word: method id in the high half, total word count (header included) in the low half.
    typedef struct packed {
        logic [15:0] id;
        logic [15:0] len;
    } header_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    function automatic logic [31:0] make_header(input logic [15:0] id, input logic [15:0] len);
        header_t hdr;
        hdr.id  = id;
        hdr.len = len;
        return hdr;
    endfunction

endpackage

// File: rtl/echo_indication_serializer_if.sv
// EchoIndication method-invocation interface: the Echo core drives the client
// side, the serializer consumes through the server side.
interface echo_indication_serializer_if;

    logic        heard__ENA;
    logic [31:0] heard_v;
    logic        heard__RDY;

    logic        heards__ENA;
    logic [15:0] heards_ah_end;
    logic [15:0] heards_ah_front_end;
    logic [7:0]  heards_ah_back_sync;
    logic [7:0]  heards_ah_sync_width;
    logic [15:0] heards_av_end;
    logic [15:0] heards_av_front_end;
    logic [7:0]  heards_av_back_sync;
    logic [7:0]  heards_av_sync_width;
    logic        heards__RDY;

    modport server (
        input  heard__ENA, heard_v,
        input  heards__ENA, heards_ah_end, heards_ah_front_end, heards_ah_back_sync,
               heards_ah_sync_width, heards_av_end, heards_av_front_end,
               heards_av_back_sync, heards_av_sync_width,
        output heard__RDY, heards__RDY
    );

    modport client (
        output heard__ENA, heard_v,
        output heards__ENA, heards_ah_end, heards_ah_front_end, heards_ah_back_sync,
               heards_ah_sync_width, heards_av_end, heards_av_front_end,
               heards_av_back_sync, heards_av_sync_width,
        input  heard__RDY, heards__RDY
    );

endinterface

// File: rtl/echo_indication_serializer.sv
// Captures one heard/heards invocation at a time into a 4-word buffer and
// streams it out as a header word plus payload, with last on the final word.
module echo_indication_serializer
    import echo_indication_pkg::state_e, echo_indication_pkg::IDLE, echo_indication_pkg::SEND,
           echo_indication_pkg::HEARD_LEN, echo_indication_pkg::HEARDS_LEN,
           echo_indication_pkg::make_header;
#(
    parameter logic [15:0] HEARD_ID  = echo_indication_pkg::HEARD_ID,
    parameter logic [15:0] HEARDS_ID = echo_indication_pkg::HEARDS_ID
) (
    input  logic                                CLK,
    input  logic                                nRST,
    echo_indication_serializer_if.server        ind,
    output logic                                out__ENA,
    output logic [31:0]                         out_data,
    output logic                                out_last,
    input  logic                                out__RDY,
    output logic [15:0]                         msg_count,
    output logic                                err
);

    state_e      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [1:0]  last_idx_q, last_idx_d;
    logic [15:0] msg_count_q, msg_count_d;
    logic        err_q, err_d;
    logic        cap_heard, cap_heards;
    logic [31:0] msg_buf_q [4];

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        last_idx_d = last_idx_q;
        msg_count_d = msg_count_q;
        err_d      = err_q;
        cap_heard  = 1'b0;
        cap_heards = 1'b0;
        unique case (state_q)
            IDLE: begin
                // heard wins a same-cycle collision; the dropped heards is flagged.
                if (ind.heard__ENA) begin
                    cap_heard  = 1'b1;
                    last_idx_d = HEARD_LEN[1:0] - 2'd1;
                    idx_d      = 2'd0;
                    state_d    = SEND;
                    if (ind.heards__ENA) err_d = 1'b1;
                end else if (ind.heards__ENA) begin
                    cap_heards = 1'b1;
                    last_idx_d = HEARDS_LEN[1:0] - 2'd1;
                    idx_d      = 2'd0;
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (out__RDY) begin
                    if (idx_q == last_idx_q) begin
                        state_d     = IDLE;
                        idx_d       = 2'd0;
                        msg_count_d = msg_count_q + 16'd1;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            idx_q       <= 2'd0;
            last_idx_q  <= 2'd0;
            msg_count_q <= 16'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            last_idx_q  <= last_idx_d;
            msg_count_q <= msg_count_d;
            err_q       <= err_d;
        end
    end

    // NOTE: the message buffer has no reset; it is only read in SEND, after a capture has filled it.
    always_ff @(posedge CLK) begin
        if (cap_heard) begin
            msg_buf_q[0] <= make_header(HEARD_ID, HEARD_LEN);
            msg_buf_q[1] <= ind.heard_v;
        end else if (cap_heards) begin
            msg_buf_q[0] <= make_header(HEARDS_ID, HEARDS_LEN);
            msg_buf_q[1] <= {ind.heards_ah_end, ind.heards_ah_front_end};
            msg_buf_q[2] <= {ind.heards_ah_back_sync, ind.heards_ah_sync_width, ind.heards_av_end};
            msg_buf_q[3] <= {ind.heards_av_front_end, ind.heards_av_back_sync, ind.heards_av_sync_width};
        end
    end

    // Outputs derive from registered state only, so reset clears them at once.
    assign out__ENA        = (state_q == SEND);
    assign out_data        = out__ENA ? msg_buf_q[idx_q] : 32'd0;
    assign out_last        = out__ENA && (idx_q == last_idx_q);
    assign ind.heard__RDY  = (state_q == IDLE);
    assign ind.heards__RDY = (state_q == IDLE);
    assign msg_count       = msg_count_q;
    assign err             = err_q;

endmodule

// File: tb/tb_echo_indication_serializer.sv
// Directed bench for echo_indication_serializer: framing, backpressure,
// collision error, count wrap and asynchronous reset mid-message.
module tb_echo_indication_serializer;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        out__ENA;
    logic [31:0] out_data;
    logic        out_last;
    logic        out__RDY;
    logic [15:0] msg_count;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;
    int xfers    = 0;

    echo_indication_serializer_if ind ();

    echo_indication_serializer dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .ind       (ind),
        .out__ENA  (out__ENA),
        .out_data  (out_data),
        .out_last  (out_last),
        .out__RDY  (out__RDY),
        .msg_count (msg_count),
        .err       (err)
    );

    always #5 CLK = ~CLK;

    // Inputs change on the falling edge; a transfer seen here lands on the next rising edge.
    always @(negedge CLK) begin
        #2;
        if (nRST && out__ENA && out__RDY) xfers++;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic expect_word(input string tag, input logic [31:0] data, input logic last);
        int waited = 0;
        while (!out__ENA && waited < 20) begin
            @(negedge CLK);
            waited++;
        end
        check({tag, "_ena"}, {31'd0, out__ENA}, 32'd1);
        check({tag, "_data"}, out_data, data);
        check({tag, "_last"}, {31'd0, out_last}, {31'd0, last});
        @(negedge CLK);
    endtask

    task automatic send_heard(input logic [31:0] v);
        ind.heard_v    = v;
        ind.heard__ENA = 1'b1;
        @(negedge CLK);
        ind.heard__ENA = 1'b0;
    endtask

    task automatic load_heards();
        ind.heards_ah_end        = 16'h0320;
        ind.heards_ah_front_end  = 16'h0330;
        ind.heards_ah_back_sync  = 8'h10;
        ind.heards_ah_sync_width = 8'h20;
        ind.heards_av_end        = 16'h01E0;
        ind.heards_av_front_end  = 16'h01EA;
        ind.heards_av_back_sync  = 8'h02;
        ind.heards_av_sync_width = 8'h03;
    endtask

    task automatic send_heards();
        load_heards();
        ind.heards__ENA = 1'b1;
        @(negedge CLK);
        ind.heards__ENA = 1'b0;
    endtask

    task automatic expect_heards(input string tag);
        expect_word({tag, "_w0"}, 32'h00010004, 1'b0);
        expect_word({tag, "_w1"}, 32'h03200330, 1'b0);
        expect_word({tag, "_w2"}, 32'h102001E0, 1'b0);
        expect_word({tag, "_w3"}, 32'h01EA0203, 1'b1);
    endtask

    initial begin
        nRST            = 1'b0;
        out__RDY        = 1'b1;
        ind.heard__ENA  = 1'b0;
        ind.heard_v     = 32'd0;
        ind.heards__ENA = 1'b0;
        load_heards();
        @(negedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);

        check("rst_ena",   {31'd0, out__ENA}, 32'd0);
        check("rst_data",  out_data, 32'd0);
        check("rst_last",  {31'd0, out_last}, 32'd0);
        check("rst_count", {16'd0, msg_count}, 32'd0);
        check("rst_err",   {31'd0, err}, 32'd0);
        check("rst_hrdy",  {31'd0, ind.heard__RDY}, 32'd1);
        check("rst_hsrdy", {31'd0, ind.heards__RDY}, 32'd1);

        // Plain heard at full throughput.
        send_heard(32'hDEADBEEF);
        check("h_rdy_busy", {31'd0, ind.heard__RDY}, 32'd0);
        expect_word("h_w0", 32'h00000002, 1'b0);
        check("h_rdy_busy2", {31'd0, ind.heard__RDY}, 32'd0);
        expect_word("h_w1", 32'hDEADBEEF, 1'b1);
        check("h_ena_drop", {31'd0, out__ENA}, 32'd0);
        check("h_rdy_back", {31'd0, ind.heard__RDY}, 32'd1);
        check("h_count",    {16'd0, msg_count}, 32'd1);

        // heards field packing.
        send_heards();
        expect_heards("hs");
        check("hs_count", {16'd0, msg_count}, 32'd2);
        check("hs_err",   {31'd0, err}, 32'd0);

        // Backpressure on the header, with an illegal heards__ENA while busy.
        xfers    = 0;
        out__RDY = 1'b0;
        send_heard(32'hCAFEF00D);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_hold_data%0d", i), out_data, 32'h00000002);
            check($sformatf("bp_hold_last%0d", i), {31'd0, out_last}, 32'd0);
            check($sformatf("bp_hold_rdy%0d", i), {31'd0, ind.heard__RDY}, 32'd0);
            ind.heards__ENA = (i == 2);
            @(negedge CLK);
        end
        ind.heards__ENA = 1'b0;
        out__RDY = 1'b1;
        expect_word("bp_w0", 32'h00000002, 1'b0);
        check("bp_rdy_mid", {31'd0, ind.heard__RDY}, 32'd0);
        expect_word("bp_w1", 32'hCAFEF00D, 1'b1);
        @(negedge CLK);
        check("bp_xfers", xfers, 32'd2);
        check("bp_ena_idle", {31'd0, out__ENA}, 32'd0);
        check("bp_err", {31'd0, err}, 32'd0);
        check("bp_count", {16'd0, msg_count}, 32'd3);

        // Simultaneous invocations: heard wins, err latches.
        ind.heard_v     = 32'h12345678;
        ind.heard__ENA  = 1'b1;
        ind.heards__ENA = 1'b1;
        @(negedge CLK);
        ind.heard__ENA  = 1'b0;
        ind.heards__ENA = 1'b0;
        expect_word("col_w0", 32'h00000002, 1'b0);
        expect_word("col_w1", 32'h12345678, 1'b1);
        check("col_idle", {31'd0, out__ENA}, 32'd0);
        check("col_err",  {31'd0, err}, 32'd1);
        @(negedge CLK);
        check("col_still_idle", {31'd0, out__ENA}, 32'd0);
        send_heards();
        expect_heards("col_hs");
        check("col_err_sticky", {31'd0, err}, 32'd1);
        check("col_count", {16'd0, msg_count}, 32'd5);

        // Count wrap from 16'hFFFF.
        force dut.msg_count_q = 16'hFFFF;
        @(negedge CLK);
        release dut.msg_count_q;
        check("wrap_pre", {16'd0, msg_count}, 32'h0000FFFF);
        send_heard(32'h0BADF00D);
        expect_word("wrap_w0", 32'h00000002, 1'b0);
        expect_word("wrap_w1", 32'h0BADF00D, 1'b1);
        check("wrap_count", {16'd0, msg_count}, 32'd0);

        // Asynchronous reset mid-heards.
        send_heards();
        expect_word("ar_w0", 32'h00010004, 1'b0);
        expect_word("ar_w1", 32'h03200330, 1'b0);
        check("ar_pre_ena", {31'd0, out__ENA}, 32'd1);
        #1 nRST = 1'b0;
        #1;
        check("ar_ena",   {31'd0, out__ENA}, 32'd0);
        check("ar_data",  out_data, 32'd0);
        check("ar_last",  {31'd0, out_last}, 32'd0);
        check("ar_count", {16'd0, msg_count}, 32'd0);
        check("ar_err",   {31'd0, err}, 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);
        check("ar_idle", {31'd0, out__ENA}, 32'd0);
        send_heard(32'h0A0B0C0D);
        expect_word("ar_h_w0", 32'h00000002, 1'b0);
        expect_word("ar_h_w1", 32'h0A0B0C0D, 1'b1);
        check("ar_h_count", {16'd0, msg_count}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
